// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg -- elastic pipeline register placed between two CPU stages.
//
// Carries an opaque packed payload (e.g. {ins, PC, lat}) under a valid/ready
// handshake. With SKID=1 a second (skid) entry lets in_ready come straight
// from a flop, so the upstream ready path does not see out_ready. With
// SKID=0 there is a single entry and in_ready is combinational.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   flush      synchronous; drops every held beat and the beat offered now
//   in_valid   upstream beat present
//   in_data    upstream payload (DATA_W bits)
//   in_ready   stage can accept a beat this cycle
//   out_valid  downstream beat present
//   out_data   downstream payload; BUBBLE_VAL while out_valid=0
//   out_ready  downstream accepts this cycle
//   stall_cnt  saturating count of cycles with out_valid & ~out_ready
//   bubble_cnt saturating count of cycles with ~out_valid & out_ready
//   clr_cnt    synchronous clear of both counters (wins over increment)
module pipe_stage_reg #(
    parameter int unsigned       DATA_W     = 96,
    parameter int unsigned       SKID       = 1,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
    parameter int unsigned       CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt,
    input  logic              clr_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                rdy_q;
    logic [DATA_W-1:0]   main_q, main_d;
    logic [DATA_W-1:0]   skid_q, skid_d;
    logic [CNT_W-1:0]    stall_q, stall_d;
    logic [CNT_W-1:0]    bubble_q, bubble_d;
    logic                in_xfer;
    logic                out_xfer;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    assign out_valid = (state_q != EMPTY);
    // Payload registers are not reset; the valid mask keeps stale data off
    // the output, so nothing partial escapes after a reset.
    assign out_data  = out_valid ? main_q : BUBBLE_VAL;

    // With SKID=0 the FSM never reaches TWO: from ONE an input transfer is
    // only possible when out_ready also drains the register.
    assign in_ready  = (SKID != 0) ? rdy_q : ((state_q == EMPTY) | out_ready);

    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_d = in_data;
                    end else if (in_xfer) begin
                        state_d = TWO;
                        skid_d  = in_data;
                    end else if (out_xfer) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (out_xfer) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_comb begin
        stall_d  = stall_q;
        bubble_d = bubble_q;
        if (clr_cnt) begin
            stall_d  = '0;
            bubble_d = '0;
        end else begin
            if (out_valid && !out_ready) begin
                stall_d = sat_inc(stall_q);
            end
            if (!out_valid && out_ready) begin
                bubble_d = sat_inc(bubble_q);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= EMPTY;
            rdy_q    <= 1'b1;
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            state_q  <= state_d;
            rdy_q    <= (state_d != TWO);
            stall_q  <= stall_d;
            bubble_q <= bubble_d;
        end
    end

    always_ff @(posedge clk) begin
        main_q <= main_d;
        skid_q <= skid_d;
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;
    localparam int DW   = 96;
    localparam int CW   = 4;
    localparam int CMAX = 15;
    localparam logic [DW-1:0] BUB0 = '0;
    localparam logic [DW-1:0] BUB1 = 96'h13;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic clr_cnt = 1'b0;
    logic [DW-1:0] in_data = '0;

    logic [1:0]         ir, ov;
    logic [1:0][DW-1:0] od;
    logic [1:0][CW-1:0] sc, bc;

    int checks = 0;
    int errors = 0;

    // Reference model: ordered list of accepted beats per instance; 'held'
    // is how many of them currently sit inside the stage.
    logic [DW-1:0] fifo [2][256];
    logic [7:0]    head [2];
    logic [7:0]    tail [2];
    int            held [2];
    int            push_cnt [2];
    int            seen [2];
    int            m_sc [2];
    int            m_bc [2];

    pipe_stage_reg #(.DATA_W(DW), .SKID(1), .BUBBLE_VAL(BUB0), .CNT_W(CW)) u_skid (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(ir[0]),
        .out_valid(ov[0]), .out_data(od[0]), .out_ready(out_ready),
        .stall_cnt(sc[0]), .bubble_cnt(bc[0]), .clr_cnt(clr_cnt)
    );

    pipe_stage_reg #(.DATA_W(DW), .SKID(0), .BUBBLE_VAL(BUB1), .CNT_W(CW)) u_flat (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(ir[1]),
        .out_valid(ov[1]), .out_data(od[1]), .out_ready(out_ready),
        .stall_cnt(sc[1]), .bubble_cnt(bc[1]), .clr_cnt(clr_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] bub(input int i);
        return (i == 0) ? BUB0 : BUB1;
    endfunction

    function automatic logic model_ready(input int i);
        if (i == 0) return held[0] < 2;
        return (held[1] == 0) || out_ready;
    endfunction

    function automatic logic [DW-1:0] rnd();
        return {$urandom, $urandom, $urandom};
    endfunction

    // Drive one cycle of inputs just after a rising edge; beats the model
    // says will be accepted at the next edge go into the expected list.
    task automatic drive(input logic v, input logic [DW-1:0] d, input logic ordy,
                         input logic fl, input logic clr);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        clr_cnt   = clr;
        for (int i = 0; i < 2; i++) begin
            if (v && !fl && reset && model_ready(i)) begin
                fifo[i][tail[i]] = d;
                tail[i] = tail[i] + 8'd1;
                push_cnt[i]++;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            head[i] = '0; tail[i] = '0; held[i] = 0;
            push_cnt[i] = 0; seen[i] = 0; m_sc[i] = 0; m_bc[i] = 0;
        end
    end

    // Monitor: compares DUT outputs with the model mid-cycle, then advances
    // the model across the coming rising edge.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!reset) begin
                    head[i] = tail[i];
                    held[i] = 0;
                    seen[i] = push_cnt[i];
                    m_sc[i] = 0;
                    m_bc[i] = 0;
                    chk($sformatf("rst_valid%0d", i), DW'(ov[i]), '0);
                    chk($sformatf("rst_data%0d", i), od[i], bub(i));
                    chk($sformatf("rst_ready%0d", i), DW'(ir[i]), DW'(1));
                    chk($sformatf("rst_stall%0d", i), DW'(sc[i]), '0);
                    chk($sformatf("rst_bubble%0d", i), DW'(bc[i]), '0);
                end else begin
                    logic ev;
                    logic [DW-1:0] ed;
                    ev = (held[i] != 0);
                    ed = ev ? fifo[i][head[i]] : bub(i);
                    chk($sformatf("out_valid%0d", i), DW'(ov[i]), DW'(ev));
                    chk($sformatf("out_data%0d", i), od[i], ed);
                    chk($sformatf("in_ready%0d", i), DW'(ir[i]), DW'(model_ready(i)));
                    chk($sformatf("stall_cnt%0d", i), DW'(sc[i]), DW'(m_sc[i]));
                    chk($sformatf("bubble_cnt%0d", i), DW'(bc[i]), DW'(m_bc[i]));
                    if (clr_cnt) begin
                        m_sc[i] = 0;
                        m_bc[i] = 0;
                    end else begin
                        if (ev && !out_ready && m_sc[i] < CMAX) m_sc[i]++;
                        if (!ev && out_ready && m_bc[i] < CMAX) m_bc[i]++;
                    end
                    if (flush) begin
                        head[i] = tail[i];
                        held[i] = 0;
                        seen[i] = push_cnt[i];
                    end else begin
                        if (ev && out_ready) begin
                            head[i] = head[i] + 8'd1;
                            held[i]--;
                        end
                        if (push_cnt[i] != seen[i]) begin
                            held[i]++;
                            seen[i] = push_cnt[i];
                        end
                    end
                end
            end
        end
    end

    initial begin
        logic [DW-1:0] a, b, c, x;
        logic pat [3];
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1;

        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // Single beat with downstream ready.
        a = 96'h0040_3000_0000_0001;
        drive(1'b1, a, 1'b1, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("t1_data", od[0], a);
        chk("t1_valid", DW'(ov[0]), DW'(1));
        chk("t1_ready", DW'(ir[0]), DW'(1));
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Backpressure fills the skid buffer; third beat refused.
        a = rnd(); b = rnd(); c = rnd();
        drive(1'b1, a, 1'b0, 1'b0, 1'b0);
        drive(1'b1, b, 1'b0, 1'b0, 1'b0);
        drive(1'b1, c, 1'b0, 1'b0, 1'b0);
        chk("t2_full_ready", DW'(ir[0]), '0);
        chk("t2_held", od[0], a);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("t2_second", od[0], b);
        repeat (3) drive(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Flush while two beats are held and a third is offered.
        drive(1'b1, rnd(), 1'b0, 1'b0, 1'b0);
        drive(1'b1, rnd(), 1'b0, 1'b0, 1'b0);
        drive(1'b1, rnd(), 1'b0, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("t3_valid", DW'(ov[0]), '0);
        chk("t3_data", od[0], BUB0);
        chk("t3_ready", DW'(ir[0]), DW'(1));
        chk("t3_flat_data", od[1], BUB1);

        // Continuous stream with out_ready toggling 1,0,1.
        for (int k = 0; k < 12; k++) drive(1'b1, rnd(), pat[k % 3], 1'b0, 1'b0);

        // Long idle with ready high saturates the bubble counter.
        repeat (20) drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("t5_sat0", DW'(bc[0]), DW'(CMAX));
        chk("t5_sat1", DW'(bc[1]), DW'(CMAX));
        drive(1'b0, '0, 1'b1, 1'b0, 1'b1);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("t5_clr0", DW'(bc[0]), '0);
        chk("t5_clr1", DW'(bc[1]), '0);

        // Random traffic with occasional flush and counter clear.
        for (int k = 0; k < 2000; k++) begin
            drive(($urandom % 4) != 0, rnd(), ($urandom % 3) != 0,
                  ($urandom % 20) == 0, ($urandom % 40) == 0);
        end

        // Asynchronous reset between edges while beats are held.
        drive(1'b1, rnd(), 1'b0, 1'b0, 1'b0);
        drive(1'b1, rnd(), 1'b0, 1'b0, 1'b0);
        drive(1'b1, rnd(), 1'b0, 1'b0, 1'b0);
        #2 reset = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("t6_valid%0d", i), DW'(ov[i]), '0);
            chk($sformatf("t6_data%0d", i), od[i], bub(i));
            chk($sformatf("t6_stall%0d", i), DW'(sc[i]), '0);
            chk($sformatf("t6_bubble%0d", i), DW'(bc[i]), '0);
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        in_valid = 1'b0;
        x = rnd();
        drive(1'b1, x, 1'b1, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("t6_after", od[0], x);
        repeat (3) drive(1'b0, '0, 1'b1, 1'b0, 1'b0);

        @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
